// File: rtl/twiddle_rotator_if.sv
// Streaming bus for the twiddle rotator: sample + twiddle in, rotated sample out,
// valid/ready on both sides.
interface twiddle_rotator_if #(
  parameter int word_length    = 16,
  parameter int word_length_tw = 14
);
  logic                             in_valid;
  logic                             in_ready;
  logic signed [word_length-1:0]    in_re;
  logic signed [word_length-1:0]    in_im;
  logic signed [word_length_tw-1:0] cos_data;
  logic signed [word_length_tw-1:0] sin_data;
  logic                             out_valid;
  logic                             out_ready;
  logic signed [word_length-1:0]    out_re;
  logic signed [word_length-1:0]    out_im;
  logic                             out_sat;
  logic                             sat_sticky;

  modport master (
    output in_valid, in_re, in_im, cos_data, sin_data, out_ready,
    input  in_ready, out_valid, out_re, out_im, out_sat, sat_sticky
  );

  modport slave (
    input  in_valid, in_re, in_im, cos_data, sin_data, out_ready,
    output in_ready, out_valid, out_re, out_im, out_sat, sat_sticky
  );
endinterface

// File: rtl/twiddle_rotator.sv
// Complex rotation (re + j*im)*(cos + j*sin) with half-up rounding and saturation.
// Three stages (capture / multiply / sum-round-saturate) sharing one stall enable.
module twiddle_rotator #(
  parameter int word_length    = 16,
  parameter int word_length_tw = 14,
  parameter int TW_FRAC        = 12
) (
  input  logic             clk,
  input  logic             rst,
  twiddle_rotator_if.slave bus
);
  localparam int STAGES = 3;
  localparam int PW     = word_length + word_length_tw;
  localparam int SW     = PW + 1;

  localparam logic signed [SW-1:0] RND     = SW'(2 ** (TW_FRAC - 1));
  localparam logic signed [SW-1:0] OUT_MAX = SW'((2 ** (word_length - 1)) - 1);
  localparam logic signed [SW-1:0] OUT_MIN = ~OUT_MAX;

  typedef struct packed {
    logic signed [word_length-1:0]    re;
    logic signed [word_length-1:0]    im;
    logic signed [word_length_tw-1:0] c;
    logic signed [word_length_tw-1:0] s;
  } smp_t;

  typedef struct packed {
    logic signed [PW-1:0] pr_c;
    logic signed [PW-1:0] pi_s;
    logic signed [PW-1:0] pr_s;
    logic signed [PW-1:0] pi_c;
  } prod_t;

  typedef struct packed {
    logic signed [word_length-1:0] re;
    logic signed [word_length-1:0] im;
    logic                          sat;
  } res_t;

  // MSB of the result flags a clip; low bits are the rounded, clamped value.
  function automatic logic [word_length:0] round_sat(input logic signed [SW-1:0] s);
    logic signed [SW-1:0] r;
    r = (s + RND) >>> TW_FRAC;
    if (r > OUT_MAX)      round_sat = {1'b1, OUT_MAX[word_length-1:0]};
    else if (r < OUT_MIN) round_sat = {1'b1, OUT_MIN[word_length-1:0]};
    else                  round_sat = {1'b0, r[word_length-1:0]};
  endfunction

  logic [STAGES:0]      vld_pipe;
  logic [STAGES:1]      vld_q;
  logic                 en;
  smp_t                 s1;
  prod_t                s2;
  res_t                 s3, s3_d;
  logic signed [SW-1:0] sum_re, sum_im;
  logic [word_length:0] rs_re, rs_im;
  logic                 sat_sticky_q;

  // A full output slot that downstream refuses freezes the whole pipe.
  assign en       = bus.out_ready | ~vld_q[STAGES];
  assign vld_pipe = {vld_q, bus.in_valid};

  always_comb begin
    sum_re = SW'(s2.pr_c) - SW'(s2.pi_s);
    sum_im = SW'(s2.pr_s) + SW'(s2.pi_c);
    rs_re  = round_sat(sum_re);
    rs_im  = round_sat(sum_im);
    s3_d.re  = rs_re[word_length-1:0];
    s3_d.im  = rs_im[word_length-1:0];
    s3_d.sat = rs_re[word_length] | rs_im[word_length];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      s1    <= '0;
      s2    <= '0;
      s3    <= '0;
    end else if (en) begin
      vld_q   <= vld_pipe[STAGES-1:0];
      s1.re   <= bus.in_re;
      s1.im   <= bus.in_im;
      s1.c    <= bus.cos_data;
      s1.s    <= bus.sin_data;
      s2.pr_c <= PW'(s1.re) * PW'(s1.c);
      s2.pi_s <= PW'(s1.im) * PW'(s1.s);
      s2.pr_s <= PW'(s1.re) * PW'(s1.s);
      s2.pi_c <= PW'(s1.im) * PW'(s1.c);
      s3      <= s3_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                             sat_sticky_q <= 1'b0;
    else if (vld_q[STAGES] && bus.out_ready && s3.sat)   sat_sticky_q <= 1'b1;
  end

  assign bus.in_ready   = en;
  assign bus.out_valid  = vld_q[STAGES];
  assign bus.out_re     = s3.re;
  assign bus.out_im     = s3.im;
  assign bus.out_sat    = s3.sat;
  assign bus.sat_sticky = sat_sticky_q;
endmodule

// File: tb/tb_twiddle_rotator.sv
// Directed bench for twiddle_rotator: hand-computed rotations, rounding,
// saturation, backpressure and mid-stream reset.
module tb_twiddle_rotator;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  twiddle_rotator_if #(.word_length(16), .word_length_tw(14)) bus ();

  twiddle_rotator #(.word_length(16), .word_length_tw(14), .TW_FRAC(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Present one sample for one cycle; returns just after the accepting edge.
  task automatic push(input int re, input int im, input int c, input int s);
    bus.in_valid = 1'b1;
    bus.in_re    = 16'(re);
    bus.in_im    = 16'(im);
    bus.cos_data = 14'(c);
    bus.sin_data = 14'(s);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic set_in(input int re, input int im, input int c, input int s);
    bus.in_valid = 1'b1;
    bus.in_re    = 16'(re);
    bus.in_im    = 16'(im);
    bus.cos_data = 14'(c);
    bus.sin_data = 14'(s);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.in_re = '0; bus.in_im = '0; bus.cos_data = '0; bus.sin_data = '0;
    #1;
    checks++;
    if ({bus.out_valid, bus.out_re, bus.out_im, bus.out_sat, bus.sat_sticky} !== 35'd0) begin
      failures++;
      $display("FAIL reset_state: got v=%0b re=%0d im=%0d sat=%0b sticky=%0b want all 0",
               bus.out_valid, bus.out_re, bus.out_im, bus.out_sat, bus.sat_sticky);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %0b want 1", bus.in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_identity();
    push(1000, -500, 4096, 0);
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL identity_latency: out_valid got %0b after 2 cycles want 0", bus.out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if ({bus.out_valid, bus.out_re, bus.out_im, bus.out_sat} !== {1'b1, 16'sd1000, -16'sd500, 1'b0}) begin
      failures++;
      $display("FAIL identity: got v=%0b re=%0d im=%0d sat=%0b want v=1 re=1000 im=-500 sat=0",
               bus.out_valid, bus.out_re, bus.out_im, bus.out_sat);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL identity_no_dup: out_valid got %0b want 0", bus.out_valid);
    end
  endtask

  task automatic test_j_rotation();
    push(1000, -500, 0, 4096);
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if ({bus.out_valid, bus.out_re, bus.out_im, bus.out_sat} !== {1'b1, 16'sd500, 16'sd1000, 1'b0}) begin
      failures++;
      $display("FAIL j_rotation: got v=%0b re=%0d im=%0d sat=%0b want v=1 re=500 im=1000 sat=0",
               bus.out_valid, bus.out_re, bus.out_im, bus.out_sat);
    end
  endtask

  task automatic test_generator_twiddle();
    push(4096, 0, -4046, -641);
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if ({bus.out_valid, bus.out_re, bus.out_im, bus.out_sat} !== {1'b1, -16'sd4046, -16'sd641, 1'b0}) begin
      failures++;
      $display("FAIL generator_twiddle: got v=%0b re=%0d im=%0d sat=%0b want v=1 re=-4046 im=-641 sat=0",
               bus.out_valid, bus.out_re, bus.out_im, bus.out_sat);
    end
  endtask

  task automatic test_rounding();
    push(3, -3, 2048, 0);
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if ({bus.out_valid, bus.out_re, bus.out_im, bus.out_sat} !== {1'b1, 16'sd2, -16'sd1, 1'b0}) begin
      failures++;
      $display("FAIL rounding_3: got v=%0b re=%0d im=%0d sat=%0b want v=1 re=2 im=-1 sat=0",
               bus.out_valid, bus.out_re, bus.out_im, bus.out_sat);
    end
    push(5, -5, 2048, 0);
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if ({bus.out_valid, bus.out_re, bus.out_im, bus.out_sat} !== {1'b1, 16'sd3, -16'sd2, 1'b0}) begin
      failures++;
      $display("FAIL rounding_5: got v=%0b re=%0d im=%0d sat=%0b want v=1 re=3 im=-2 sat=0",
               bus.out_valid, bus.out_re, bus.out_im, bus.out_sat);
    end
  endtask

  task automatic test_saturation();
    push(32767, -32768, 4096, 4096);
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if ({bus.out_valid, bus.out_re, bus.out_im, bus.out_sat} !== {1'b1, 16'sd32767, -16'sd1, 1'b1}) begin
      failures++;
      $display("FAIL saturation: got v=%0b re=%0d im=%0d sat=%0b want v=1 re=32767 im=-1 sat=1",
               bus.out_valid, bus.out_re, bus.out_im, bus.out_sat);
    end
    checks++;
    if (bus.sat_sticky !== 1'b0) begin
      failures++;
      $display("FAIL sticky_before_transfer: got %0b want 0", bus.sat_sticky);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.sat_sticky !== 1'b1) begin
      failures++;
      $display("FAIL sticky_set: got %0b want 1", bus.sat_sticky);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.sat_sticky !== 1'b1) begin
      failures++;
      $display("FAIL sticky_hold: got %0b want 1", bus.sat_sticky);
    end
  endtask

  task automatic test_back_to_back();
    set_in(1000, -500, 4096, 0);
    @(posedge clk); #1;
    set_in(1000, -500, 0, 4096);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({bus.out_valid, bus.out_re, bus.out_im} !== {1'b1, 16'sd1000, -16'sd500}) begin
      failures++;
      $display("FAIL b2b_first: got v=%0b re=%0d im=%0d want v=1 re=1000 im=-500",
               bus.out_valid, bus.out_re, bus.out_im);
    end
    @(posedge clk); #1;
    checks++;
    if ({bus.out_valid, bus.out_re, bus.out_im} !== {1'b1, 16'sd500, 16'sd1000}) begin
      failures++;
      $display("FAIL b2b_second: got v=%0b re=%0d im=%0d want v=1 re=500 im=1000",
               bus.out_valid, bus.out_re, bus.out_im);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic signed [15:0] exp_re [8];
    logic signed [15:0] exp_im [8];
    logic signed [15:0] held_re, held_im;
    logic prev_stall;
    int sent, recv, cyc;
    sent = 0; recv = 0; cyc = 0; prev_stall = 1'b0;
    held_re = '0; held_im = '0;
    for (int k = 0; k < 8; k++) begin
      exp_re[k] = 16'(k * 1000 - 3000);
      exp_im[k] = 16'(500 - k * 77);
    end
    checks++;
    if (bus.sat_sticky !== 1'b1) begin
      failures++;
      $display("FAIL sticky_persist: got %0b want 1", bus.sat_sticky);
    end
    while (recv < 8 && cyc < 60) begin
      bus.out_ready = !(cyc >= 5 && cyc < 9);
      if (sent < 8) set_in(int'(exp_re[sent]), int'(exp_im[sent]), 4096, 0);
      else bus.in_valid = 1'b0;
      #1;
      if (bus.out_valid && !bus.out_ready) begin
        checks++;
        if (bus.in_ready !== 1'b0) begin
          failures++;
          $display("FAIL stall_in_ready: cycle %0d got %0b want 0", cyc, bus.in_ready);
        end
        if (prev_stall) begin
          checks++;
          if ({bus.out_re, bus.out_im} !== {held_re, held_im}) begin
            failures++;
            $display("FAIL stall_hold: cycle %0d got re=%0d im=%0d want re=%0d im=%0d",
                     cyc, bus.out_re, bus.out_im, held_re, held_im);
          end
        end
        held_re = bus.out_re; held_im = bus.out_im; prev_stall = 1'b1;
      end else begin
        prev_stall = 1'b0;
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if ({bus.out_re, bus.out_im} !== {exp_re[recv], exp_im[recv]}) begin
          failures++;
          $display("FAIL stream_data[%0d]: got re=%0d im=%0d want re=%0d im=%0d",
                   recv, bus.out_re, bus.out_im, exp_re[recv], exp_im[recv]);
        end
        recv++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
      @(posedge clk); #1;
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    checks++;
    if (recv != 8 || sent != 8) begin
      failures++;
      $display("FAIL stream_count: got sent=%0d recv=%0d want 8/8 within 60 cycles", sent, recv);
    end
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL stream_no_extra: out_valid got %0b want 0", bus.out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset();
    set_in(111, 222, 4096, 0);
    @(posedge clk); #1;
    set_in(333, 444, 4096, 0);
    @(posedge clk); #1;
    set_in(555, 666, 4096, 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++;
    if ({bus.out_valid, bus.out_re, bus.out_im} !== {1'b1, 16'sd111, 16'sd222}) begin
      failures++;
      $display("FAIL mid_reset_pre: got v=%0b re=%0d im=%0d want v=1 re=111 im=222",
               bus.out_valid, bus.out_re, bus.out_im);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.out_valid, bus.out_re, bus.out_im, bus.out_sat, bus.sat_sticky} !== 35'd0) begin
      failures++;
      $display("FAIL mid_reset_clear: got v=%0b re=%0d im=%0d sat=%0b sticky=%0b want all 0",
               bus.out_valid, bus.out_re, bus.out_im, bus.out_sat, bus.sat_sticky);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin
        failures++;
        $display("FAIL mid_reset_stale: cycle %0d out_valid got %0b want 0", i, bus.out_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_j_rotation();
    test_generator_twiddle();
    test_rounding();
    test_back_to_back();
    test_saturation();
    test_backpressure();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
